// File: rtl/spi_sclk_sequencer.sv
// rtl/spi_sclk_sequencer.sv - SPI serial clock and chip-select sequencer
//
// Purpose: frames one SPI transaction as SETUP, RUN and HOLD phases of D cycles each.
//   SETUP holds SCLK at CPOL. RUN produces 2N SCLK edges with edge strobes. HOLD holds
//   SCLK at CPOL again. A done pulse marks the first IDLE cycle.
//
// Ports:
//   in_clock        system clock; all logic runs on its rising edge
//   in_reset        asynchronous active-high reset
//   in_start        transaction request; sampled only in IDLE
//   in_divisor      SCLK half-period in in_clock cycles (0 behaves as 1)
//   in_bit_count    SCLK cycles per transaction (0 ignores the request)
//   in_cpol         SCLK idle level
//   in_abort        (only with SPI_SCLK_SEQ_ABORT_EN) drop the current transaction
//   out_sclk        generated serial clock
//   out_cs_n        active-low chip select
//   out_busy        high while a transaction is in progress
//   out_lead_edge   pulse in the cycle SCLK leaves CPOL
//   out_trail_edge  pulse in the cycle SCLK returns to CPOL
//   out_done        pulse in the first IDLE cycle after a completed transaction
//
// Option macro: SPI_SCLK_SEQ_ABORT_EN adds the in_abort port.
module spi_sclk_sequencer #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [DIV_WIDTH-1:0] in_divisor,
  input  logic [CNT_WIDTH-1:0] in_bit_count,
  input  logic                 in_cpol,
`ifdef SPI_SCLK_SEQ_ABORT_EN
  input  logic                 in_abort,
`endif
  output logic                 out_sclk,
  output logic                 out_cs_n,
  output logic                 out_busy,
  output logic                 out_lead_edge,
  output logic                 out_trail_edge,
  output logic                 out_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_HOLD} state_t;

  state_t               r_state, w_state;
  logic [DIV_WIDTH-1:0] r_div, w_div;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
  logic [CNT_WIDTH-1:0] r_n, w_n;
  // One bit wider than the bit count so that 2N never wraps.
  logic [CNT_WIDTH:0]   r_edges, w_edges;
  logic                 r_cpol, w_cpol;
  logic                 r_sclk, w_sclk;
  logic                 r_cs_n, w_cs_n;
  logic                 r_busy, w_busy;
  logic                 r_lead, w_lead;
  logic                 r_trail, w_trail;
  logic                 r_done, w_done;

  logic                 w_phase_end;
  logic [CNT_WIDTH:0]   w_last_edge;
  logic                 w_abort;

  // r_div is never 0 outside IDLE, so this marks the last cycle of a D-cycle phase.
  assign w_phase_end = (r_cnt == (r_div - DIV_WIDTH'(1)));
  assign w_last_edge = {r_n, 1'b0};

`ifdef SPI_SCLK_SEQ_ABORT_EN
  assign w_abort = in_abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_edges <= '0;
      r_cpol  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_cnt   <= w_cnt;
      r_n     <= w_n;
      r_edges <= w_edges;
      r_cpol  <= w_cpol;
      r_sclk  <= w_sclk;
      r_cs_n  <= w_cs_n;
      r_busy  <= w_busy;
      r_lead  <= w_lead;
      r_trail <= w_trail;
      r_done  <= w_done;
    end
  end

  // All outputs are registered. Each strobe is computed with the SCLK value it goes with.
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_cnt   = r_cnt;
    w_n     = r_n;
    w_edges = r_edges;
    w_cpol  = r_cpol;
    w_sclk  = r_sclk;
    w_cs_n  = r_cs_n;
    w_busy  = r_busy;
    w_lead  = 1'b0;
    w_trail = 1'b0;
    w_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt   = '0;
        w_edges = '0;
        w_sclk  = in_cpol;
        w_cs_n  = 1'b1;
        w_busy  = 1'b0;
        if (in_start && (in_bit_count != '0)) begin
          w_state = ST_SETUP;
          w_div   = (in_divisor == '0) ? DIV_WIDTH'(1) : in_divisor;
          w_n     = in_bit_count;
          w_cpol  = in_cpol;
          w_cs_n  = 1'b0;
          w_busy  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_phase_end) begin
          w_cnt   = '0;
          w_state = ST_RUN;
          w_sclk  = ~r_sclk;
          w_lead  = 1'b1;
          w_edges = (CNT_WIDTH+1)'(1);
        end else begin
          w_cnt = r_cnt + DIV_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (w_phase_end) begin
          w_cnt = '0;
          // The last RUN phase follows the N-th trailing edge; SCLK already sits at CPOL.
          if (r_edges == w_last_edge) begin
            w_state = ST_HOLD;
          end else begin
            w_sclk  = ~r_sclk;
            w_edges = r_edges + (CNT_WIDTH+1)'(1);
            // Odd-numbered edges lead and even-numbered edges trail.
            w_lead  = ~r_edges[0];
            w_trail = r_edges[0];
          end
        end else begin
          w_cnt = r_cnt + DIV_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (w_phase_end) begin
          w_cnt   = '0;
          w_state = ST_IDLE;
          w_sclk  = r_cpol;
          w_cs_n  = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // An abort leaves silently: no done pulse and no edge strobes.
    if (w_abort && (r_state != ST_IDLE)) begin
      w_state = ST_IDLE;
      w_cnt   = '0;
      w_edges = '0;
      w_sclk  = r_cpol;
      w_cs_n  = 1'b1;
      w_busy  = 1'b0;
      w_lead  = 1'b0;
      w_trail = 1'b0;
      w_done  = 1'b0;
    end
  end

  assign out_sclk       = r_sclk;
  assign out_cs_n       = r_cs_n;
  assign out_busy       = r_busy;
  assign out_lead_edge  = r_lead;
  assign out_trail_edge = r_trail;
  assign out_done       = r_done;

endmodule

// File: doc/spi_sclk_sequencer.md
SPI_SCLK_SEQUENCER -- requirements
Module: spi_sclk_sequencer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the half-period divisor.
REQ-002 SHALL have parameter CNT_WIDTH, default 6, width of the bit-count input.
REQ-003 SHALL have port in_clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port in_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_start  input  1  transaction request, sampled only in IDLE.
REQ-006 SHALL have port in_divisor  input  DIV_WIDTH  SCLK half-period in in_clock cycles; 0 treated as 1.
REQ-007 SHALL have port in_bit_count  input  CNT_WIDTH  SCLK cycles per transaction; 0 means request ignored.
REQ-008 SHALL have port in_cpol  input  1  SCLK idle level.
REQ-009 SHALL have port out_sclk  output  1  generated serial clock.
REQ-010 SHALL have port out_cs_n  output  1  active-low chip select.
REQ-011 SHALL have port out_busy  output  1  high while a transaction is in progress.
REQ-012 SHALL have port out_lead_edge  output  1  one-cycle pulse coincident with each SCLK leading edge.
REQ-013 SHALL have port out_trail_edge  output  1  one-cycle pulse coincident with each SCLK trailing edge.
REQ-014 SHALL have port out_done  output  1  one-cycle pulse on transaction completion.

Function
REQ-015 SHALL implement states IDLE, SETUP, RUN, HOLD.
REQ-016 In IDLE, in_start=1 with in_bit_count!=0 SHALL latch in_divisor (D), in_bit_count (N), in_cpol and move to SETUP on the next edge; in_start with N=0 SHALL be ignored.
REQ-017 in_divisor, in_bit_count, in_cpol changes while out_busy=1 SHALL have no effect; in_start while out_busy=1 SHALL be ignored, not queued.
REQ-018 A half-period counter SHALL count 0..D-1 and restart on each phase boundary; every phase lasts exactly D cycles.
REQ-019 SETUP SHALL last D cycles with out_cs_n=0, out_busy=1, out_sclk=latched cpol.
REQ-020 RUN SHALL toggle out_sclk every D cycles, starting with a leading edge (away from cpol), for exactly 2N edges.
REQ-021 out_lead_edge/out_trail_edge SHALL assert in the same cycle out_sclk takes its new value.
REQ-022 After the N-th trailing edge, state SHALL move to HOLD for D cycles with out_cs_n=0 and out_sclk=cpol.
REQ-023 HOLD end SHALL enter IDLE with out_cs_n=1, out_busy=0 and out_done=1 for exactly that first IDLE cycle.
REQ-024 out_busy SHALL be high for exactly (2N+2)*D cycles per transaction.
REQ-025 in_start in the out_done cycle SHALL be accepted (back-to-back, no dead cycle beyond that one).
REQ-026 In IDLE, out_sclk SHALL follow in_cpol combinationally-free, registered one cycle.
REQ-027 Edge counter SHALL be CNT_WIDTH+1 bits so N=2^CNT_WIDTH-1 does not wrap.

Reset
REQ-028 in_reset=1 SHALL immediately force IDLE, counters 0, out_sclk=0, out_cs_n=1, out_busy=0, out_lead_edge=0, out_trail_edge=0, out_done=0.
REQ-029 Reset mid-transaction SHALL abandon it without out_done; first in_start after release SHALL behave as from power-up.

Configuration
REQ-030 Macro SPI_SCLK_SEQ_ABORT_EN defined SHALL add port in_abort (input, 1): in any non-IDLE state, in_abort=1 SHALL enter IDLE next edge with out_cs_n=1, out_sclk=cpol, out_busy=0, no out_done pulse; in_abort in IDLE ignored; abort has priority over start.
REQ-031 Macro undefined SHALL omit in_abort; transactions SHALL always run to completion unless reset.

Verification
REQ-032 Reset asserted mid-RUN -> all outputs at REQ-028 values same cycle; no out_done.
REQ-033 D=2, N=8, cpol=0, start -> 8 SCLK pulses high 2 cycles/low 2 cycles, out_busy high 36 cycles, 8 lead and 8 trail pulses, one out_done.
REQ-034 D=0, N=1, cpol=1 -> treated as D=1: SCLK low 1 cycle then high, out_busy high 4 cycles, out_done once.
REQ-035 in_start held high continuously, D=1, N=2 -> transactions back-to-back, one done pulse per 6 busy cycles, out_cs_n high only in the done cycle.
REQ-036 N=0 start -> no state change, out_busy stays 0; in_divisor changed mid-transaction -> timing unchanged.
REQ-037 With SPI_SCLK_SEQ_ABORT_EN, D=3, N=4, abort after 2nd leading edge -> IDLE next cycle, out_cs_n=1, no out_done; next start completes normally.
